// File: rtl/segled_scan_sched_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan scheduler.
package segled_pkg;

    // Code sent to the hex decoder when nothing should be lit.
    localparam logic [3:0] SEG_CODE_BLANK = 4'hF;

    // Bit positions inside the 2-bit write attribute field.
    localparam int ATTR_BLINK = 1;
    localparam int ATTR_BLANK = 0;

    // One display buffer entry.
    typedef struct packed {
        logic [3:0] data;
        logic       blink;
        logic       blank;
    } seg_entry_t;

    // Scan slot phase: all digits off, then the selected digit shown.
    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_t;

    // Which write port won the most recent arbitration.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    localparam seg_entry_t SEG_ENTRY_RESET = '{data: SEG_CODE_BLANK, blink: 1'b0, blank: 1'b1};

    // Build a buffer entry from a write request's data and attribute fields.
    function automatic seg_entry_t make_entry(input logic [3:0] data, input logic [1:0] attr);
        seg_entry_t e;
        e.data  = data;
        e.blink = attr[ATTR_BLINK];
        e.blank = attr[ATTR_BLANK];
        return e;
    endfunction

endpackage

// File: rtl/segled_scan_sched_if.sv
// Write-request channel into the display buffer (valid/ready handshake).
interface segled_scan_sched_if;
    import segled_pkg::*;

    logic       valid;
    logic       ready;
    logic [2:0] digit;
    logic [3:0] data;
    logic [1:0] attr;

    modport master (output valid, output digit, output data, output attr, input ready);
    modport slave  (input valid, input digit, input data, input attr, output ready);

endinterface

// File: rtl/segled_scan_sched_wr_arb.sv
// Two-port round-robin write arbiter and the per-digit display buffer it feeds.
module segled_wr_arb
    import segled_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                  CLK_50M,
    input  logic                  RST_N,
    segled_scan_sched_if.slave    a_port,
    segled_scan_sched_if.slave    b_port,
    input  logic [2:0]            rd_idx,
    output seg_entry_t            rd_entry,
    output logic                  wr_err
);

    localparam logic [3:0] NUM_DIGITS_L = 4'(NUM_DIGITS);

    grant_t     last_grant_reg;
    seg_entry_t buf_reg [8];
    logic       wr_err_reg;

    logic       grant_a;
    logic       grant_b;
    logic       wr_acc;
    logic       wr_in_range;
    logic       wr_en;
    logic [2:0] wr_idx;
    seg_entry_t wr_entry;

    // Grant selection: a lone requester wins; on contention the port that did not win last time wins.
    always_comb begin
        grant_a     = RST_N && a_port.valid && (!b_port.valid || (last_grant_reg == GRANT_B));
        grant_b     = RST_N && b_port.valid && (!a_port.valid || (last_grant_reg == GRANT_A));
        wr_acc      = grant_a || grant_b;
        wr_idx      = grant_a ? a_port.digit : b_port.digit;
        wr_entry    = grant_a ? make_entry(a_port.data, a_port.attr)
                              : make_entry(b_port.data, b_port.attr);
        wr_in_range = ({1'b0, wr_idx} < NUM_DIGITS_L);
        wr_en       = wr_acc && wr_in_range;
    end

    assign a_port.ready = grant_a;
    assign b_port.ready = grant_b;

    // Remember the winner of every accepted write for round-robin fairness.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            last_grant_reg <= GRANT_B;
        end else if (wr_acc) begin
            last_grant_reg <= grant_a ? GRANT_A : GRANT_B;
        end
    end

    // Display buffer; entries at or beyond NUM_DIGITS are never written.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 8; i++) begin
                buf_reg[i] <= SEG_ENTRY_RESET;
            end
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_idx == 3'(i)) begin
                    buf_reg[i] <= wr_entry;
                end
            end
        end
    end

    // Flag accepted writes that target a digit that does not exist.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= wr_acc && !wr_in_range;
        end
    end

    assign wr_err = wr_err_reg;

    // Read port forwards a write landing on the same edge, so a write in the latch cycle is seen this slot.
    always_comb begin
        rd_entry = buf_reg[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_entry = wr_entry;
        end
    end

endmodule

// File: rtl/segled_scan_sched.sv
// Scan scheduler: time-multiplexes the display buffer onto active-low digit enables
// with a blanking gap per slot, plus blink timing and frame markers.
module segled_scan_sched
    import segled_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int TICK_CYCLES  = 5000,
    parameter int BLANK_CYCLES = 50,
    parameter int BLINK_TICKS  = 2500
) (
    input  logic                  CLK_50M,
    input  logic                  RST_N,
    segled_scan_sched_if.slave    a_port,
    segled_scan_sched_if.slave    b_port,
    output logic                  wr_err,
    output logic [NUM_DIGITS-1:0] SEG_EN,
    output logic [3:0]            scan_code,
    output logic                  frame_start
);

    localparam int CNT_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int TICK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LATCH = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_TICKS - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);

    scan_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [2:0]            idx_reg, idx_next;
    seg_entry_t            show_reg, show_next;
    logic [TICK_W-1:0]     tick_reg, tick_next;
    logic                  phase_reg, phase_next;

    logic [NUM_DIGITS-1:0] seg_en_reg;
    logic [3:0]            scan_code_reg, scan_code_next;
    logic                  frame_start_reg, frame_start_next;

    logic                  slot_end;
    logic                  latch_cycle;
    logic                  visible_next;
    logic [NUM_DIGITS-1:0] digit_on_next;
    seg_entry_t            rd_entry;

    segled_wr_arb #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_wr_arb (
        .CLK_50M  (CLK_50M),
        .RST_N    (RST_N),
        .a_port   (a_port),
        .b_port   (b_port),
        .rd_idx   (idx_reg),
        .rd_entry (rd_entry),
        .wr_err   (wr_err)
    );

    // Scan state register, slot counter, digit index, show latch and blink timing.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= SCAN_BLANK;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            show_reg  <= SEG_ENTRY_RESET;
            tick_reg  <= '0;
            phase_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            show_reg  <= show_next;
            tick_reg  <= tick_next;
            phase_reg <= phase_next;
        end
    end

    // Next-state logic: blank gap, latch on its last cycle, show until the slot ends.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CNT_W'(1);
        idx_next    = idx_reg;
        show_next   = show_reg;
        tick_next   = tick_reg;
        phase_next  = phase_reg;
        slot_end    = (cnt_reg == CNT_LAST);
        latch_cycle = (state_reg == SCAN_BLANK) && (cnt_reg == CNT_LATCH);

        if (latch_cycle) begin
            state_next = SCAN_SHOW;
            show_next  = rd_entry;
        end

        if (slot_end) begin
            state_next = SCAN_BLANK;
            cnt_next   = '0;
            idx_next   = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
            if (tick_reg == TICK_LAST) begin
                tick_next  = '0;
                phase_next = !phase_reg;
            end else begin
                tick_next  = tick_reg + TICK_W'(1);
            end
        end

        visible_next     = (state_next == SCAN_SHOW) && !show_next.blank
                           && !(show_next.blink && phase_next);
        scan_code_next   = (state_next == SCAN_SHOW) ? show_next.data : SEG_CODE_BLANK;
        frame_start_next = latch_cycle && (idx_reg == 3'd0);
    end

    // Per-digit enable decode of the upcoming cycle.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_en
        assign digit_on_next[gi] = visible_next && (idx_next == 3'(gi));
    end

    // Outputs are registered so the digit drivers never see decode glitches.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            seg_en_reg      <= '1;
            scan_code_reg   <= SEG_CODE_BLANK;
            frame_start_reg <= 1'b0;
        end else begin
            seg_en_reg      <= ~digit_on_next;
            scan_code_reg   <= scan_code_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign SEG_EN      = seg_en_reg;
    assign scan_code   = scan_code_reg;
    assign frame_start = frame_start_reg;

endmodule
